// File: rtl/pal_line_scheduler.sv
// PAL line scheduler: counts VDG lines, shapes output hsync, and stalls the VDG
// at two points per field to insert synthetic padding lines (262 -> 312 lines).
//
// state   | meaning
// S_PASS  | idle, waiting for a VDG hsync edge
// S_PULSE | emitting the output sync pulse for a real line
// S_PAD   | VDG held, emitting synthetic lines
module pal_line_scheduler #(
  parameter int PULSE_WIDTH = 11,
  parameter int LINE_CLKS   = 228,
  parameter int TOP_AT      = 13,
  parameter int TOP_PAD     = 25,
  parameter int BOT_AT      = 230,
  parameter int BOT_PAD     = 25
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       HS_N,
  input  logic       FS_N,
  input  logic       ENABLE,
  output logic       HS_OUT_N,
  output logic       VDG_HOLD,
  output logic       PAD_ACTIVE,
  output logic       LINE_ODD,
  output logic [8:0] LINE_CNT
);

  localparam int MAX_PAD = (TOP_PAD > BOT_PAD) ? TOP_PAD : BOT_PAD;
  localparam int TW = (LINE_CLKS > 2) ? $clog2(LINE_CLKS) : 1;
  localparam int PW = (MAX_PAD > 1) ? $clog2(MAX_PAD + 1) : 1;

  localparam logic [1:0] S_PASS  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;

  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_WIDTH - 1);
  localparam logic [TW-1:0] LINE_LOAD  = TW'(LINE_CLKS - 1);
  localparam logic [PW-1:0] TOP_LOAD   = PW'(TOP_PAD - 1);
  localparam logic [PW-1:0] BOT_LOAD   = PW'(BOT_PAD - 1);
  localparam logic [8:0]    TOP_LINE   = 9'(TOP_AT);
  localparam logic [8:0]    BOT_LINE   = 9'(BOT_AT);
  localparam logic          TOP_ON     = (TOP_PAD > 0);
  localparam logic          BOT_ON     = (BOT_PAD > 0);

  logic [1:0]    state;
  logic          hs_meta, hs_sync, hs_prev;
  logic          fs_meta, fs_sync, fs_prev;
  logic          top_done, bot_done;
  logic [TW-1:0] pulse_tmr;
  logic [TW-1:0] line_tmr;
  logic [PW-1:0] pad_left;

  logic       hs_edge, fs_edge;
  logic [8:0] cnt_base, cnt_next;
  logic       top_hit, bot_hit;

  assign hs_edge  = hs_prev & ~hs_sync;
  assign fs_edge  = fs_prev & ~fs_sync;
  // A coincident field edge clears count and flags before the line is evaluated.
  assign cnt_base = fs_edge ? 9'd0 : LINE_CNT;
  assign cnt_next = (cnt_base == 9'd511) ? cnt_base : cnt_base + 9'd1;
  assign top_hit  = ENABLE & TOP_ON & (cnt_next == TOP_LINE) & (fs_edge | ~top_done);
  assign bot_hit  = ENABLE & BOT_ON & (cnt_next == BOT_LINE) & (fs_edge | ~bot_done);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      {hs_meta, hs_sync, hs_prev} <= 3'b111;
      {fs_meta, fs_sync, fs_prev} <= 3'b111;
    end else begin
      {hs_meta, hs_sync, hs_prev} <= {HS_N, hs_meta, hs_sync};
      {fs_meta, fs_sync, fs_prev} <= {FS_N, fs_meta, fs_sync};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_PASS;
      HS_OUT_N   <= 1'b1;
      VDG_HOLD   <= 1'b0;
      PAD_ACTIVE <= 1'b0;
      LINE_ODD   <= 1'b0;
      LINE_CNT   <= 9'd0;
      top_done   <= 1'b0;
      bot_done   <= 1'b0;
      pulse_tmr  <= '0;
      line_tmr   <= '0;
      pad_left   <= '0;
    end else begin
      if (fs_edge) begin
        LINE_CNT <= 9'd0;
        top_done <= 1'b0;
        bot_done <= 1'b0;
      end
      case (state)
        S_PASS: begin
          if (hs_edge) begin
            LINE_CNT  <= cnt_next;
            HS_OUT_N  <= 1'b0;
            LINE_ODD  <= ~LINE_ODD;
            pulse_tmr <= PULSE_LOAD;
            line_tmr  <= LINE_LOAD;
            if (top_hit || bot_hit) begin
              VDG_HOLD   <= 1'b1;
              PAD_ACTIVE <= 1'b1;
              state      <= S_PAD;
              if (top_hit) begin
                top_done <= 1'b1;
                pad_left <= TOP_LOAD;
              end else begin
                bot_done <= 1'b1;
                pad_left <= BOT_LOAD;
              end
            end else begin
              state <= S_PULSE;
            end
          end
        end
        S_PULSE: begin
          if (pulse_tmr == '0) begin
            HS_OUT_N <= 1'b1;
            state    <= S_PASS;
          end else begin
            pulse_tmr <= pulse_tmr - 1'b1;
          end
        end
        S_PAD: begin
          if (!HS_OUT_N) begin
            if (pulse_tmr == '0) HS_OUT_N <= 1'b1;
            else pulse_tmr <= pulse_tmr - 1'b1;
          end
          // Each line boundary starts a new pulse; the last one is the held real line.
          if (line_tmr == '0) begin
            HS_OUT_N  <= 1'b0;
            LINE_ODD  <= ~LINE_ODD;
            pulse_tmr <= PULSE_LOAD;
            line_tmr  <= LINE_LOAD;
            if (pad_left == '0) begin
              VDG_HOLD   <= 1'b0;
              PAD_ACTIVE <= 1'b0;
              state      <= S_PULSE;
            end else begin
              pad_left <= pad_left - 1'b1;
            end
          end else begin
            line_tmr <= line_tmr - 1'b1;
          end
        end
        default: state <= S_PASS;
      endcase
    end
  end

endmodule

// File: doc/pal_line_scheduler.md
Name: pal_line_scheduler

Overview:
- Sequences horizontal-sync pulse generation for the Dragon PAL conversion.
- Counts VDG lines per field. At two programmable points it stalls the VDG (VDG_HOLD) and inserts synthetic padding lines, stretching the 262-line field to PAL 312 lines.
- Drives the shaped output sync pulse and a per-line odd/even toggle to the downstream video logic.

Parameters:
- PULSE_WIDTH, 11, CLK cycles HS_OUT_N is held low per output line; must be < LINE_CLKS.
- LINE_CLKS, 228, CLK cycles per synthetic padding line.
- TOP_AT, 13, input line number that triggers top padding.
- TOP_PAD, 25, synthetic lines inserted at the top; 0 disables.
- BOT_AT, 230, input line number that triggers bottom padding.
- BOT_PAD, 25, synthetic lines inserted at the bottom; 0 disables.

Ports:
- CLK  input  1  VDG-rate system clock; all state on the rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- HS_N  input  1  VDG horizontal sync, active low, asynchronous to CLK.
- FS_N  input  1  VDG field sync, active low, asynchronous to CLK.
- ENABLE  input  1  PAL padding enable; sampled only at a trigger.
- HS_OUT_N  output  1  shaped horizontal sync to video output, active low.
- VDG_HOLD  output  1  high stalls the VDG clock.
- PAD_ACTIVE  output  1  high while synthetic lines are being emitted.
- LINE_ODD  output  1  toggles at the start of every output line.
- LINE_CNT  output  9  input-line count since the last FS_N fall.

Behaviour:
- Reset: async, takes effect immediately. HS_OUT_N=1, VDG_HOLD=0, PAD_ACTIVE=0, LINE_ODD=0, LINE_CNT=0, top/bottom done flags cleared, state PASS.
- Synchronisers: HS_N and FS_N each pass through 2 flops, then a falling-edge detect. A trigger cycle T is the 3rd rising CLK edge after the input falls (setup met).
- FS edge at T: LINE_CNT=0 and both done flags cleared. Any pad sequence in progress completes unaffected.
- HS edge at T: LINE_CNT increments, saturating at 511. Trigger comparisons use the post-increment value.
- States: PASS, PULSE, PAD.
- PASS, HS edge, no pad condition:
  - HS_OUT_N=0 from T for PULSE_WIDTH cycles (state PULSE), then 1 and back to PASS.
  - LINE_ODD toggles at T.
- Pad condition, evaluated at T:
  - ENABLE=1, new LINE_CNT==TOP_AT, top flag clear, TOP_PAD>0.
  - Or the same with BOT_AT / bottom flag / BOT_PAD.
- PAD entry (pad condition true at T):
  - At T: VDG_HOLD=1, PAD_ACTIVE=1, the matching done flag is set.
  - Synthetic line k (k=1..N) starts at T+(k-1)*LINE_CLKS. Each start drives HS_OUT_N low for PULSE_WIDTH cycles and toggles LINE_ODD.
- PAD release at T+N*LINE_CLKS:
  - VDG_HOLD=0, PAD_ACTIVE=0.
  - The real line's pulse starts in the same cycle (HS_OUT_N=0, LINE_ODD toggles), then state PULSE.
- Input edges:
  - HS edges detected during PAD are ignored; no count, no pulse.
  - HS edges detected during PULSE are ignored.
  - A pending PULSE is never truncated.
- Simultaneous HS and FS edges in the same cycle: the FS reset applies first. The HS increment then yields LINE_CNT=1, and triggers are evaluated against 1.
- Each pad window fires at most once per field. Without an intervening FS, a repeated LINE_CNT match does not retrigger.
- Counters inside PULSE and PAD are sized from the parameters, clog2 of LINE_CLKS and of max(TOP_PAD, BOT_PAD)+1.
- Reset asserted mid-PAD: VDG_HOLD drops immediately. After reset release, the top window re-arms and fires at the 13th HS edge even without an FS edge.

Test Plan:
1. Assert RESET_N=0 with HS_N/FS_N toggling -> HS_OUT_N=1, VDG_HOLD=0, PAD_ACTIVE=0, LINE_ODD=0, LINE_CNT=0 throughout.
2. ENABLE=0, one FS fall, then 262 HS falls spaced 228 CLK -> 262 HS_OUT_N pulses, each 11 CLK low, each starting 3 CLK after HS_N falls; LINE_CNT=262; VDG_HOLD never high.
3. ENABLE=1, FS then HS edges; at the 13th edge (cycle T) -> VDG_HOLD high for exactly 5700 CLK; 25 synthetic pulses at T+0, T+228 … T+5472; real pulse at T+5700; LINE_ODD toggles 26 times over the window.
4. ENABLE=1, full field of 262 input lines -> 312 HS_OUT_N pulses per field; VDG_HOLD high 11400 CLK total; a second field behaves identically.
5. Pull RESET_N low during the 10th synthetic line of the top pad -> VDG_HOLD=0 and HS_OUT_N=1 asynchronously. After release with no FS, padding starts again at the 13th HS edge.
6. HS glitch 5 CLK into an output pulse, plus HS and FS falling in the same CLK -> glitch ignored (pulse still 11 CLK, count unchanged); coincident edges leave LINE_CNT=1.
